// File: rtl/seg_scan_driver_pkg.sv
// Shared constants, FSM states and active-low hex segment table for the 7-segment scan driver.
package seg_scan_driver_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'd0,
    ST_GUARD  = 2'd1,
    ST_DRIVE  = 2'd2
  } state_t;

  // {g,f,e,d,c,b,a} active-low; entry n sits at bits [7n+6:7n]
  localparam logic [16*7-1:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg_scan_driver_hex_to_seg7.sv
// Combinational 4-bit hex to 7-segment (active-low) decoder.
module hex_to_seg7
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[7*nibble +: 7];

endmodule

// File: rtl/seg_scan_driver.sv
// 4-digit common-anode 7-segment scan driver: per-frame snapshot, anti-ghost guard blank,
// leading-zero blanking and per-digit blink. All outputs registered.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int GUARD_CYCLES = 16,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  refresh,
  input  logic        ref_sign,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_mask,
  input  logic [3:0]  blink_mask,
  input  logic        lzb_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  state_t        state, state_nxt;
  logic [GW-1:0] gcnt, gcnt_nxt;
  logic [BW-1:0] bcnt;
  logic          blink_off;

  logic [15:0] sh_digits;
  logic [3:0]  sh_dp, sh_blank, sh_blink;
  logic        sh_lzb;

  logic        frame_start;
  logic [3:0]  nib;
  logic [6:0]  dec_seg;
  logic [3:0]  lz_mask;
  logic        drive, hide_all, hide_seg;

  assign frame_start = ref_sign && (refresh == 2'd0);

  always_comb begin
    state_nxt = state;
    gcnt_nxt  = gcnt;
    case (state)
      ST_UNSYNC: begin
        if (frame_start) begin
          state_nxt = (GUARD_CYCLES == 0) ? ST_DRIVE : ST_GUARD;
          gcnt_nxt  = '0;
        end
      end
      ST_GUARD: begin
        if (ref_sign) begin
          gcnt_nxt = '0;
        end else if (gcnt == GUARD_LAST) begin
          state_nxt = ST_DRIVE;
        end else begin
          gcnt_nxt = gcnt + 1'b1;
        end
      end
      ST_DRIVE: begin
        if (ref_sign) begin
          state_nxt = (GUARD_CYCLES == 0) ? ST_DRIVE : ST_GUARD;
          gcnt_nxt  = '0;
        end
      end
      default: state_nxt = ST_UNSYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_UNSYNC;
      gcnt      <= '0;
      bcnt      <= '0;
      blink_off <= 1'b0;
      sh_digits <= '0;
      sh_dp     <= '0;
      sh_blank  <= '0;
      sh_blink  <= '0;
      sh_lzb    <= 1'b0;
    end else begin
      state <= state_nxt;
      gcnt  <= gcnt_nxt;
      if (frame_start) begin
        sh_digits <= digits;
        sh_dp     <= dp_in;
        sh_blank  <= blank_mask;
        sh_blink  <= blink_mask;
        sh_lzb    <= lzb_en;
        if (bcnt == BLINK_LAST) begin
          bcnt      <= '0;
          blink_off <= ~blink_off;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
    end
  end

  assign nib = sh_digits[4*refresh +: 4];

  hex_to_seg7 u_dec (
    .nibble (nib),
    .seg    (dec_seg)
  );

  // A digit is a leading zero only if it and every more significant digit are zero
  always_comb begin
    lz_mask    = 4'b0000;
    lz_mask[3] = sh_lzb && (sh_digits[15:12] == 4'h0);
    lz_mask[2] = lz_mask[3] && (sh_digits[11:8] == 4'h0);
    lz_mask[1] = lz_mask[2] && (sh_digits[7:4] == 4'h0);
  end

  // The strobe cycle itself is already dark so the new index never flashes before the guard
  assign drive    = (state == ST_DRIVE) && !(ref_sign && (GUARD_CYCLES != 0));
  assign hide_all = sh_blank[refresh] || (sh_blink[refresh] && blink_off);
  assign hide_seg = hide_all || lz_mask[refresh];

  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= drive ? ~(4'b0001 << refresh) : AN_OFF;
      seg        <= (drive && !hide_seg) ? dec_seg : SEG_BLANK;
      dp         <= !(drive && !hide_all && sh_dp[refresh]);
      frame_done <= frame_start;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized self-checking bench for seg_scan_driver against a frame-level behavioural model.
module tb_seg_scan_driver;

  localparam int G  = 16;
  localparam int BF = 2;
  localparam int DW = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  refresh = 2'd0;
  logic        ref_sign = 1'b0;
  logic [15:0] digits = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank_mask = 4'h0;
  logic [3:0]  blink_mask = 4'h0;
  logic        lzb_en = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] hex_ref [16];

  // reference model state
  bit          m_synced;
  int          m_frame;
  logic [15:0] m_dig;
  logic [3:0]  m_dp, m_blank, m_blink;
  logic        m_lzb;

  always #10 clk = ~clk;

  seg_scan_driver #(.GUARD_CYCLES(G), .BLINK_FRAMES(BF)) dut (
    .clk        (clk),
    .rst        (rst),
    .refresh    (refresh),
    .ref_sign   (ref_sign),
    .digits     (digits),
    .dp_in      (dp_in),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .lzb_en     (lzb_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  task automatic model_reset();
    m_synced = 0;
    m_frame  = 0;
    m_dig    = '0;
    m_dp     = '0;
    m_blank  = '0;
    m_blink  = '0;
    m_lzb    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ref_sign = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One digit slot: strobe index k, then hold it for DW clocks checking every cycle
  task automatic scan_digit(input int k, input string tag);
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp, exp_fd, lit, off, full, lz;
    bit         fs;
    @(negedge clk);
    refresh  = 2'(k);
    ref_sign = 1'b1;
    fs = (k == 0);
    if (fs) begin
      m_synced = 1;
      m_frame++;
      m_dig   = digits;
      m_dp    = dp_in;
      m_blank = blank_mask;
      m_blink = blink_mask;
      m_lzb   = lzb_en;
    end
    for (int j = 0; j < DW; j++) begin
      @(negedge clk);
      ref_sign = 1'b0;
      lit  = m_synced && (j > G);
      off  = ((m_frame / BF) % 2) == 1;
      full = m_blank[k] || (m_blink[k] && off);
      lz   = m_lzb && (k != 0) && ((m_dig >> (4 * k)) == 16'h0);
      exp_an  = lit ? ~(4'b0001 << k) : 4'hF;
      exp_seg = (lit && !full && !lz) ? hex_ref[m_dig[4*k +: 4]] : 7'h7F;
      exp_dp  = !(lit && !full && m_dp[k]);
      exp_fd  = fs && (j == 0);
      n_cmp += 4;
      if (an !== exp_an) begin
        n_bad++;
        $display("FAIL %s an k=%0d j=%0d got %h want %h", tag, k, j, an, exp_an);
      end
      if (seg !== exp_seg) begin
        n_bad++;
        $display("FAIL %s seg k=%0d j=%0d got %h want %h", tag, k, j, seg, exp_seg);
      end
      if (dp !== exp_dp) begin
        n_bad++;
        $display("FAIL %s dp k=%0d j=%0d got %b want %b", tag, k, j, dp, exp_dp);
      end
      if (frame_done !== exp_fd) begin
        n_bad++;
        $display("FAIL %s frame_done k=%0d j=%0d got %b want %b", tag, k, j, frame_done, exp_fd);
      end
    end
  endtask

  task automatic run_frame(input string tag);
    for (int k = 0; k < 4; k++) scan_digit(k, tag);
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      n_cmp++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_idle c=%0d got an=%h seg=%h dp=%b fd=%b want F/7F/1/0",
                 c, an, seg, dp, frame_done);
      end
    end
  endtask

  task automatic test_unsync();
    // strobes on non-zero indices must not start a frame
    scan_digit(2, "unsync");
    scan_digit(3, "unsync");
  endtask

  task automatic test_basic();
    digits = 16'h1234; dp_in = 4'h0; blank_mask = 4'h0; blink_mask = 4'h0; lzb_en = 1'b0;
    run_frame("basic");
    run_frame("basic");
  endtask

  task automatic test_snapshot();
    digits = 16'h1234;
    scan_digit(0, "snapshot");
    scan_digit(1, "snapshot");
    scan_digit(2, "snapshot");
    digits = 16'h5678;
    dp_in  = 4'hF;
    scan_digit(3, "snapshot");
    run_frame("snapshot");
    dp_in = 4'h0;
  endtask

  task automatic test_lzb();
    lzb_en = 1'b1;
    digits = 16'h0070;
    run_frame("lzb");
    digits = 16'h0000;
    run_frame("lzb_zero");
    dp_in = 4'b1010;
    run_frame("lzb_dp");
    digits = 16'h0305;
    run_frame("lzb_inner");
    lzb_en = 1'b0;
    dp_in  = 4'h0;
  endtask

  task automatic test_blink();
    do_reset();
    blink_mask = 4'b0001;
    for (int f = 0; f < 6; f++) begin
      digits = 16'($urandom);
      run_frame("blink");
    end
    blink_mask = 4'h0;
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      digits     = 16'($urandom);
      dp_in      = 4'($urandom);
      blank_mask = 4'($urandom_range(0, 15)) & 4'($urandom);
      blink_mask = 4'($urandom);
      lzb_en     = 1'($urandom);
      if ($urandom_range(0, 1) == 1) digits = digits & 16'h00FF;
      scan_digit(0, "random");
      // mid-frame input churn must stay invisible until the next frame start
      digits = 16'($urandom); dp_in = 4'($urandom); blank_mask = 4'($urandom);
      scan_digit(1, "random");
      blink_mask = 4'($urandom); lzb_en = 1'($urandom);
      scan_digit(2, "random");
      scan_digit(3, "random");
    end
    blank_mask = 4'h0; blink_mask = 4'h0; lzb_en = 1'b0; dp_in = 4'h0;
  endtask

  task automatic test_reset_strobe();
    digits = 16'h9ABC;
    blink_mask = 4'b0001;
    scan_digit(0, "rst_strobe");
    scan_digit(1, "rst_strobe");
    @(negedge clk);
    rst = 1'b1;
    ref_sign = 1'b1;
    refresh = 2'd0;
    @(negedge clk);
    n_cmp++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_strobe got an=%h seg=%h dp=%b fd=%b want F/7F/1/0", an, seg, dp, frame_done);
    end
    rst = 1'b0;
    ref_sign = 1'b0;
    model_reset();
    scan_digit(1, "rst_unsync");
    for (int f = 0; f < 4; f++) run_frame("rst_blink");
    blink_mask = 4'h0;
  endtask

  initial begin
    hex_ref = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    model_reset();
    test_reset();
    test_unsync();
    test_basic();
    test_snapshot();
    test_lzb();
    test_blink();
    test_random();
    test_reset_strobe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
